uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Next-generation UART receiver, successor to the fixed 8N1 Uart8 rx path. Frame format is set by parameters:
//  data width, parity mode, stop-bit count and oversampling ratio. Each bit is taken by a 3-sample majority vote.
//  Received words leave on a valid/ready output register with framing, parity and overrun flags.
//  Sits between the board rx pin and any byte consumer (FIFO, command decoder).
// PARAMETERS
//  CLOCK_RATE  12000000  system clock in Hz
//  BAUD_RATE   9600      line rate in baud
//  OVERSAMPLE  16        sample ticks per bit; even, >=8
//  DATA_BITS   8         data width, 5..9, LSB first on line
//  PARITY      0         0=none, 1=even, 2=odd
//  STOP_BITS   1         1 or 2
// PORTS
//  clk           in   1          system clock
//  reset_n       in   1          asynchronous reset, active low
//  rx_en         in   1          receiver enable
//  rx_in         in   1          asynchronous serial line, idle high
//  rx_busy       out  1          frame in progress (state != IDLE)
//  rx_valid      out  1          rx_data holds an unconsumed word
//  rx_ready      in   1          consumer accepts the word when rx_valid&rx_ready
//  rx_data       out  DATA_BITS  received word
//  rx_err_frame  out  1          qualified by rx_valid: a stop bit sampled 0
//  rx_err_parity out  1          qualified by rx_valid: parity mismatch
//  rx_err_overrun out 1          1-cycle pulse: a completed word was dropped
//  rx_break      out  1          1-cycle pulse; present only with UART_RX_BREAK_DETECT_EN
// BEHAVIOUR
//  - Clock and reset: one clock; reset is asynchronous and active-low.
//  - Reset values: all outputs 0; synchroniser flops 1; state IDLE.
//  - Input sync: rx_in passes through 2 flops; all logic uses the synchronised value.
//  - Tick generator: DIV = round(CLOCK_RATE/(BAUD_RATE*OVERSAMPLE)); at the defaults DIV=78.
//    Produces a 1-cycle tick every DIV clocks. Restarts on start detection so bit phase is aligned.
//  - Bit vote: sample counter s runs 0..OVERSAMPLE-1 per bit. The bit value is the majority of the
//    samples at s = M-1, M, M+1, where M = OVERSAMPLE/2. Samples at any other s are ignored.
//  - FSM: IDLE -> START -> DATA (DATA_BITS bits) -> [PARITY] -> STOP (STOP_BITS bits) -> IDLE.
//  - IDLE: if rx_en=1 and the line is 0 while armed, go to START. Armed = the line was seen 1
//    since the last frame.
//  - START: if the vote is 1, the start was a glitch: return to IDLE with no output.
//  - STOP: the last stop vote finishes the frame at s = M+1. The FSM returns to IDLE without
//    waiting for the rest of the bit. A stop vote of 0 sets frame_err; the receiver then stays
//    disarmed until the line returns to 1.
//  - Delivery: on the clock after the final vote:
//    - if rx_valid=0, or (rx_valid=1 and rx_ready=1) in that cycle: load rx_data and the error
//      flags, set rx_valid=1;
//    - otherwise: drop the new word, keep the old one, and pulse rx_err_overrun.
//  - Handshake: rx_valid falls the cycle after rx_valid&rx_ready. The error flags clear with it.
//  - Parity: even mode means ^{data,parity}==0; odd mode means ^{data,parity}==1. The word is
//    still delivered when parity fails.
//  - rx_en=0 mid-frame: return to IDLE on the next clock and discard the partial frame.
//    rx_valid and rx_data are untouched.
//  - reset_n low mid-frame: immediate return to reset values; no partial word is delivered.
// CONFIGURATION
//  UART_RX_BREAK_DETECT_EN
//  - Defined: a frame whose data bits, parity bit and stop bits all vote 0 is a break.
//    It is not delivered. rx_break pulses for 1 cycle. The receiver is disarmed until the line is 1.
//  - Undefined: no rx_break port. The same frame is delivered as data 0 with rx_err_frame=1.
// STRUCTURE
//  - uart_pkg holds the parity mode constants (PAR_NONE/EVEN/ODD), the FSM state typedef
//    and a DIV calculation function.
//  - Sub-module uart_baud_tick holds the divider counter, sync restart input and tick output.
//  - The FSM, vote, shifter and output register live in uart_rx_param.
// TESTING (defaults, 12 MHz clock, 9600 baud, bit = 16*78 clocks)
//  1. 8N1, send 0x55 -> rx_valid=1, rx_data=0x55, all error flags 0;
//     rx_valid falls 1 cycle after rx_ready.
//  2. 8N1, 0x55 with a stop-bit glitch low during s=1..4 -> delivered 0x55, rx_err_frame=0.
//     Glitch low across s=7..9 -> rx_err_frame=1.
//  3. Start pulse low for 4 samples only -> rx_busy returns to 0 after the START vote;
//     rx_valid never asserts.
//  4. PARITY=1, 0xA5 sent with parity bit 1 -> rx_data=0xA5, rx_err_parity=1.
//     Same frame with parity bit 0 -> rx_err_parity=0.
//  5. Send 0x11 then 0x22 with rx_ready held 0 -> rx_data stays 0x11,
//     rx_err_overrun pulses once at the end of 0x22.
//  6. reset_n low mid-data, then a 0x3C frame -> outputs 0 during reset, then 0x3C delivered cleanly.
//     With the macro defined, 0x00 with stop bit 0 -> rx_break pulse, no rx_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, receiver state type and baud divider helper for uart_rx_param
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  function automatic int calc_div(input int clock_rate, input int baud_rate, input int oversample);
    return (clock_rate + baud_rate * oversample / 2) / (baud_rate * oversample);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle tick every DIV clocks, phase restarted on restart
module uart_baud_tick #(
  parameter int DIV = 78
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);
  localparam int CW = $clog2(DIV) > 0 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (restart || cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
      tick <= !restart && cnt == CW'(DIV - 1);
    end
  end
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parameterised UART receiver with 3-sample majority vote and valid/ready output.
// UART_RX_BREAK_DETECT_EN adds rx_break: an all-zero frame pulses rx_break instead of being delivered.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_en,
  input  logic                 rx_in,
  output logic                 rx_busy,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_err_frame,
  output logic                 rx_err_parity,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic                 rx_break,
`endif
  output logic                 rx_err_overrun
);
  localparam int DIV = calc_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int SW  = $clog2(OVERSAMPLE);
`ifdef UART_RX_BREAK_DETECT_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif
  state_t state;
  logic sy1, sy2, armed, v0, v1, tick, restart, vote, at_vote, glitch, finish, done;
  logic ferr, stop_one, par_bit, perr, is_brk, scnt;
  logic [SW-1:0] s;
  logic [3:0] bcnt;
  logic [DATA_BITS-1:0] sh;
  uart_baud_tick #(.DIV(DIV)) u_tick (.clk(clk), .reset_n(reset_n), .restart(restart), .tick(tick));
  assign restart = state == IDLE && rx_en && !sy2 && armed;
  assign at_vote = tick && s == SW'(M + 1);
  assign vote    = (v0 & v1) | (v0 & sy2) | (v1 & sy2);
  assign glitch  = state == START && at_vote && vote;
  assign finish  = rx_en && state == STOP && at_vote && scnt == 1'(STOP_BITS - 1);
  assign perr    = PARITY == PAR_EVEN ? ^{sh, par_bit} : PARITY == PAR_ODD ? ~^{sh, par_bit} : 1'b0;
  assign is_brk  = BRK_EN && sh == '0 && !par_bit && !stop_one;
  assign rx_busy = state != IDLE;
  // Frame ends mid stop bit; armed needs a fresh high line before the next start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sy1      <= 1'b1;
      sy2      <= 1'b1;
      armed    <= 1'b0;
      v0       <= 1'b0;
      v1       <= 1'b0;
      s        <= '0;
      bcnt     <= '0;
      scnt     <= 1'b0;
      sh       <= '0;
      ferr     <= 1'b0;
      stop_one <= 1'b0;
      par_bit  <= 1'b0;
      done     <= 1'b0;
    end else begin
      sy1   <= rx_in;
      sy2   <= sy1;
      armed <= (finish || glitch) ? 1'b0 : (sy2 ? 1'b1 : armed);
      done  <= finish;
      if (tick) begin
        s <= s == SW'(OVERSAMPLE - 1) ? '0 : s + SW'(1);
        if (s == SW'(M - 1)) v0 <= sy2;
        if (s == SW'(M)) v1 <= sy2;
      end
      if (restart) s <= '0;
      if (!rx_en) state <= IDLE;
      else case (state)
        IDLE: if (restart) begin
          state    <= START;
          bcnt     <= '0;
          scnt     <= 1'b0;
          ferr     <= 1'b0;
          stop_one <= 1'b0;
          par_bit  <= 1'b0;
        end
        START: if (at_vote) state <= vote ? IDLE : DATA;
        DATA: if (at_vote) begin
          sh   <= {vote, sh[DATA_BITS-1:1]};
          bcnt <= bcnt + 4'd1;
          if (bcnt == 4'(DATA_BITS - 1)) state <= PARITY == PAR_NONE ? STOP : PAR;
        end
        PAR: if (at_vote) begin
          par_bit <= vote;
          state   <= STOP;
        end
        STOP: if (at_vote) begin
          ferr     <= ferr | ~vote;
          stop_one <= stop_one | vote;
          scnt     <= 1'b1;
          if (scnt == 1'(STOP_BITS - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_valid       <= 1'b0;
      rx_data        <= '0;
      rx_err_frame   <= 1'b0;
      rx_err_parity  <= 1'b0;
      rx_err_overrun <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      rx_break       <= 1'b0;
`endif
    end else begin
      rx_err_overrun <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      rx_break       <= done && is_brk;
`endif
      if (rx_valid && rx_ready) begin
        rx_valid      <= 1'b0;
        rx_err_frame  <= 1'b0;
        rx_err_parity <= 1'b0;
      end
      if (done && !is_brk) begin
        if (!rx_valid || rx_ready) begin
          rx_valid      <= 1'b1;
          rx_data       <= sh;
          rx_err_frame  <= ferr;
          rx_err_parity <= perr;
        end else rx_err_overrun <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and random frames on an 8N1 and an 8E2 receiver against a bit-level line model
module tb_uart_rx_param;
  localparam int OS  = 16;
  localparam int DIV = 5;
  localparam int BIT = OS * DIV;
  localparam int CR  = 9600 * OS * DIV;
  logic clk = 1'b0, reset_n = 1'b0, rx_en = 1'b1;
  logic rx_in0 = 1'b1, rx_in1 = 1'b1, rdy0 = 1'b0, rdy1 = 1'b0;
  logic busy0, busy1, val0, val1, fe0, fe1, pe0, pe1, ovr0, ovr1, brk0, brk1;
  logic [7:0] dat0, dat1;
  int checks = 0, errors = 0, ovr0_cnt = 0, ovr1_cnt = 0, brk0_cnt = 0;
  always #5 clk = ~clk;
  uart_rx_param #(.CLOCK_RATE(CR)) u0 (
    .clk(clk), .reset_n(reset_n), .rx_en(rx_en), .rx_in(rx_in0), .rx_busy(busy0),
    .rx_valid(val0), .rx_ready(rdy0), .rx_data(dat0), .rx_err_frame(fe0), .rx_err_parity(pe0),
`ifdef UART_RX_BREAK_DETECT_EN
    .rx_break(brk0),
`endif
    .rx_err_overrun(ovr0));
  uart_rx_param #(.CLOCK_RATE(CR), .PARITY(1), .STOP_BITS(2)) u1 (
    .clk(clk), .reset_n(reset_n), .rx_en(rx_en), .rx_in(rx_in1), .rx_busy(busy1),
    .rx_valid(val1), .rx_ready(rdy1), .rx_data(dat1), .rx_err_frame(fe1), .rx_err_parity(pe1),
`ifdef UART_RX_BREAK_DETECT_EN
    .rx_break(brk1),
`endif
    .rx_err_overrun(ovr1));
`ifndef UART_RX_BREAK_DETECT_EN
  assign brk0 = 1'b0;
  assign brk1 = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (ovr0) ovr0_cnt <= ovr0_cnt + 1;
    if (ovr1) ovr1_cnt <= ovr1_cnt + 1;
    if (brk0) brk0_cnt <= brk0_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit u, input logic v);
    if (u) rx_in1 = v; else rx_in0 = v;
  endtask

  // Each bit is OS line windows of DIV clocks; windows gs..ge of bit gbit are forced low.
  task automatic send(input bit u, input logic [7:0] d, input bit pflip, input logic [1:0] stops,
                      input int gbit, input int gs, input int ge);
    logic q[$];
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (u) begin
      q.push_back((^d) ^ pflip);
      q.push_back(stops[0]);
      q.push_back(stops[1]);
    end else q.push_back(stops[0]);
    for (int i = 0; i < q.size(); i++)
      for (int k = 0; k < OS; k++) begin
        drive(u, (i == gbit && k >= gs && k <= ge) ? 1'b0 : q[i]);
        repeat (DIV) @(negedge clk);
      end
    drive(u, 1'b1);
    repeat (20) @(negedge clk);
  endtask

  task automatic take(input bit u, input logic [7:0] d, input bit fe, input bit pe, input string tag);
    int n = 0;
    while (!(u ? val1 : val0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " valid"}, u ? val1 : val0, 1);
    chk({tag, " data"}, u ? dat1 : dat0, d);
    chk({tag, " frame_err"}, u ? fe1 : fe0, fe);
    chk({tag, " parity_err"}, u ? pe1 : pe0, pe);
    if (u) rdy1 = 1'b1; else rdy0 = 1'b1;
    @(negedge clk);
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    chk({tag, " valid_fall"}, u ? val1 : val0, 0);
    chk({tag, " flags_clear"}, u ? {fe1, pe1} : {fe0, pe0}, 0);
  endtask

  initial begin
    logic [7:0] d;
    bit pf;
    int ov, bk;
    repeat (5) @(negedge clk);
    chk("rst valid", val0, 0);
    chk("rst data", dat0, 0);
    chk("rst busy", busy0, 0);
    chk("rst flags", {fe0, pe0, ovr0, brk0, val1, busy1}, 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    send(0, 8'h55, 0, 2'b11, -1, 0, 0);
    take(0, 8'h55, 0, 0, "t1 0x55");
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      send(0, d, 0, 2'b11, -1, 0, 0);
      take(0, d, 0, 0, "rand 8N1");
    end
    send(0, 8'h55, 0, 2'b11, 9, 2, 5);
    take(0, 8'h55, 0, 0, "stop glitch early");
    send(0, 8'h55, 0, 2'b11, 9, 8, 10);
    take(0, 8'h55, 1, 0, "stop glitch mid");
    rx_in0 = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    rx_in0 = 1'b1;
    chk("start glitch busy", busy0, 1);
    repeat (10 * DIV) @(negedge clk);
    chk("start glitch idle", busy0, 0);
    repeat (12 * BIT) @(negedge clk);
    chk("start glitch no word", val0, 0);
    ov = ovr0_cnt;
    send(0, 8'h11, 0, 2'b11, -1, 0, 0);
    send(0, 8'h22, 0, 2'b11, -1, 0, 0);
    chk("overrun pulses", ovr0_cnt - ov, 1);
    take(0, 8'h11, 0, 0, "overrun keep");
    repeat (BIT) @(negedge clk);
    chk("overrun dropped", val0, 0);
    fork
      send(0, 8'h5A, 0, 2'b11, -1, 0, 0);
      begin
        repeat (3 * BIT) @(negedge clk);
        rx_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("rx_en abort busy", busy0, 0);
      end
    join
    rx_en = 1'b1;
    repeat (BIT) @(negedge clk);
    chk("rx_en abort no word", val0, 0);
    send(0, 8'h42, 0, 2'b11, -1, 0, 0);
    chk("pre-reset word", {val0, dat0}, {1'b1, 8'h42});
    fork
      send(0, 8'hF0, 0, 2'b11, -1, 0, 0);
      begin
        repeat (2 * BIT + 10) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid reset outputs", {val0, dat0, busy0, fe0, pe0}, 0);
        repeat (3 * BIT) @(negedge clk);
        reset_n = 1'b1;
      end
    join
    chk("post reset no word", val0, 0);
    send(0, 8'h3C, 0, 2'b11, -1, 0, 0);
    take(0, 8'h3C, 0, 0, "after reset 0x3C");
    bk = brk0_cnt;
    send(0, 8'h00, 0, 2'b00, -1, 0, 0);
`ifdef UART_RX_BREAK_DETECT_EN
    chk("break pulse", brk0_cnt - bk, 1);
    chk("break no word", val0, 0);
`else
    chk("break absent", brk0_cnt - bk, 0);
    take(0, 8'h00, 1, 0, "zero frame");
`endif
    send(1, 8'hA5, 1, 2'b11, -1, 0, 0);
    take(1, 8'hA5, 0, 1, "even par bad");
    send(1, 8'hA5, 0, 2'b11, -1, 0, 0);
    take(1, 8'hA5, 0, 0, "even par good");
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      pf = 1'($urandom_range(0, 1));
      send(1, d, pf, 2'b11, -1, 0, 0);
      take(1, d, 0, pf, "rand 8E2");
    end
    send(1, 8'h96, 0, 2'b01, -1, 0, 0);
    take(1, 8'h96, 1, 0, "second stop low");
    chk("8E2 no overrun", ovr1_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
